// File: rtl/hvirq_pkg.sv
// Shared constants and configuration type for the hypervisor virtual-interrupt unit.
package hvirq_pkg;

  typedef struct packed {
    int   XLEN;
    logic S_MODE;
    logic U_MODE;
    logic M_MODE;
  } cvw_t;

  localparam cvw_t CVW_DEFAULT = '{XLEN: 64, S_MODE: 1'b1, U_MODE: 1'b1, M_MODE: 1'b1};

  localparam int VSSI_BIT = 2;
  localparam int VSTI_BIT = 6;
  localparam int VSEI_BIT = 10;

  localparam logic [4:0] CAUSE_VSSI = 5'd1;
  localparam logic [4:0] CAUSE_VSTI = 5'd5;
  localparam logic [4:0] CAUSE_VSEI = 5'd9;

  localparam int VGEIN_HI = 17;
  localparam int VGEIN_LO = 12;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;

endpackage

// File: rtl/hvirqsync.sv
// Parameterized-width two-flop synchronizer with synchronous active-high reset.
module hvirqsync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/hvirq.sv
// Hypervisor virtual-interrupt unit: hgeip capture, SGEIP/VSEIP and VS interrupt selection.
// Define HVIRQ_SYNC_EN to put a 2-flop synchronizer in front of the hgeip capture flops.
module hvirq
  import hvirq_pkg::*;
#(
  parameter cvw_t P      = CVW_DEFAULT,
  parameter int   GEILEN = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GEILEN-1:0] GEIRaw,
  input  logic              StallW,
  input  logic [P.XLEN-1:0] HSTATUS_REGW,
  input  logic [P.XLEN-1:0] HIDELEG_REGW,
  input  logic [P.XLEN-1:0] HIE_REGW,
  input  logic [11:0]       HVIP_REGW,
  input  logic [P.XLEN-1:0] HGEIE_REGW,
  input  logic              VSSIEW,
  input  logic [1:0]        PrivilegeModeW,
  input  logic              VirtModeW,
  output logic [P.XLEN-1:0] HGEIP_REGW,
  output logic              SGEIPM,
  output logic              VSEIPM,
  output logic              VSIntPendingM,
  output logic [4:0]        VSIntCauseM
);

  logic [GEILEN-1:0] gei_sync;

`ifdef HVIRQ_SYNC_EN
  hvirqsync #(.WIDTH(GEILEN)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (GEIRaw),
    .q     (gei_sync)
  );
`else
  assign gei_sync = GEIRaw;
`endif

  logic [P.XLEN-1:0] hgeip_d, hgeip_q;
  logic              sgeip_d, sgeip_q;
  logic              vseip_d, vseip_q;
  logic              pend_d, pend_q;
  logic [4:0]        cause_d, cause_q;
  logic [5:0]        vgein;
  logic              vgein_hit;
  logic              vssi, vsti, vsei, takeable;

  assign vgein = HSTATUS_REGW[VGEIN_HI:VGEIN_LO];

  // Guest lines land in bits GEILEN:1; bit 0 and everything above GEILEN stay 0.
  always_comb begin
    hgeip_d             = '0;
    hgeip_d[GEILEN:1]   = gei_sync;
  end

  // VGEIN of 0 or beyond GEILEN matches no loop index, so it selects nothing.
  always_comb begin
    vgein_hit = 1'b0;
    for (int i = 1; i <= GEILEN; i++) begin
      if (vgein == 6'(i)) vgein_hit = hgeip_q[i];
    end
  end

  always_comb begin
    sgeip_d  = |(hgeip_q[GEILEN:1] & HGEIE_REGW[GEILEN:1]);
    vseip_d  = HVIP_REGW[VSEI_BIT] | vgein_hit;
    vsei     = vseip_d & HIE_REGW[VSEI_BIT] & HIDELEG_REGW[VSEI_BIT];
    vssi     = HVIP_REGW[VSSI_BIT] & HIE_REGW[VSSI_BIT] & HIDELEG_REGW[VSSI_BIT];
    vsti     = HVIP_REGW[VSTI_BIT] & HIE_REGW[VSTI_BIT] & HIDELEG_REGW[VSTI_BIT];
    takeable = VirtModeW &&
               ((PrivilegeModeW == PRIV_U) || ((PrivilegeModeW == PRIV_S) && VSSIEW));
    pend_d   = takeable & (vsei | vssi | vsti);
    cause_d  = '0;
    if (takeable) begin
      if (vsei)      cause_d = CAUSE_VSEI;
      else if (vssi) cause_d = CAUSE_VSSI;
      else if (vsti) cause_d = CAUSE_VSTI;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hgeip_q <= '0;
      sgeip_q <= 1'b0;
      vseip_q <= 1'b0;
      pend_q  <= 1'b0;
      cause_q <= '0;
    end else if (!StallW) begin
      hgeip_q <= hgeip_d;
      sgeip_q <= sgeip_d;
      vseip_q <= vseip_d;
      pend_q  <= pend_d;
      cause_q <= cause_d;
    end
  end

  assign HGEIP_REGW    = hgeip_q;
  assign SGEIPM        = sgeip_q;
  assign VSEIPM        = vseip_q;
  assign VSIntPendingM = pend_q;
  assign VSIntCauseM   = cause_q;

  // Only a few CSR fields matter here; the rest are deliberately ignored.
  logic unused_inputs;
  assign unused_inputs = ^{HSTATUS_REGW, HIDELEG_REGW, HIE_REGW, HGEIE_REGW, HVIP_REGW,
                           P.S_MODE, P.U_MODE, P.M_MODE};

endmodule

// File: tb/tb_hvirq.sv
// Scoreboard bench for hvirq: directed steps push expectations, a negedge monitor checks them.
module tb_hvirq;
  import hvirq_pkg::*;

  localparam int GEILEN = 7;
  localparam int XLEN   = CVW_DEFAULT.XLEN;
`ifdef HVIRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [GEILEN-1:0] GEIRaw;
  logic              StallW;
  logic [XLEN-1:0]   HSTATUS_REGW, HIDELEG_REGW, HIE_REGW, HGEIE_REGW;
  logic [11:0]       HVIP_REGW;
  logic              VSSIEW;
  logic [1:0]        PrivilegeModeW;
  logic              VirtModeW;
  logic [XLEN-1:0]   HGEIP_REGW;
  logic              SGEIPM, VSEIPM, VSIntPendingM;
  logic [4:0]        VSIntCauseM;

  hvirq #(.P(CVW_DEFAULT), .GEILEN(GEILEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .GEIRaw         (GEIRaw),
    .StallW         (StallW),
    .HSTATUS_REGW   (HSTATUS_REGW),
    .HIDELEG_REGW   (HIDELEG_REGW),
    .HIE_REGW       (HIE_REGW),
    .HVIP_REGW      (HVIP_REGW),
    .HGEIE_REGW     (HGEIE_REGW),
    .VSSIEW         (VSSIEW),
    .PrivilegeModeW (PrivilegeModeW),
    .VirtModeW      (VirtModeW),
    .HGEIP_REGW     (HGEIP_REGW),
    .SGEIPM         (SGEIPM),
    .VSEIPM         (VSEIPM),
    .VSIntPendingM  (VSIntPendingM),
    .VSIntCauseM    (VSIntCauseM)
  );

  always #5 clk = ~clk;

  typedef enum int {K_HGEIP, K_SGEIP, K_VSEIP, K_PEND, K_CAUSE} kind_e;
  typedef struct {
    string       name;
    int          due;
    kind_e       kind;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [63:0] actual(kind_e k);
    case (k)
      K_HGEIP: return 64'(HGEIP_REGW);
      K_SGEIP: return {63'd0, SGEIPM};
      K_VSEIP: return {63'd0, VSEIPM};
      K_PEND:  return {63'd0, VSIntPendingM};
      default: return {59'd0, VSIntCauseM};
    endcase
  endfunction

  // Monitor: pops every expectation that has come due and compares it with the DUT.
  initial begin
    exp_t        e;
    logic [63:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e   = sb.pop_front();
        act = actual(e.kind);
        n_cmp++;
        if (e.due != cyc || act !== e.val) begin
          n_mis++;
          $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h (due cyc %0d)",
                   e.name, cyc, act, e.val, e.due);
        end else begin
          $display("ok   %s @cyc %0d: 0x%0h", e.name, cyc, act);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input kind_e k, input int dly,
                            input logic [63:0] v);
    sb.push_back('{name, cyc + dly, k, v});
  endtask

  task automatic expect_outs(input string tag, input int dly, input logic s, input logic v,
                             input logic p, input logic [4:0] c);
    expect_val({tag, ".sgeip"}, K_SGEIP, dly, {63'd0, s});
    expect_val({tag, ".vseip"}, K_VSEIP, dly, {63'd0, v});
    expect_val({tag, ".pend"},  K_PEND,  dly, {63'd0, p});
    expect_val({tag, ".cause"}, K_CAUSE, dly, {59'd0, c});
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() > 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain_timeout: %0d entries left, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every input busy: reset must still win.
    reset = 1'b1; StallW = 1'b0; GEIRaw = 7'h7F;
    HSTATUS_REGW = '0; HIDELEG_REGW = 64'h444; HIE_REGW = 64'h444;
    HVIP_REGW = 12'h444; HGEIE_REGW = '1; VSSIEW = 1'b1;
    PrivilegeModeW = PRIV_U; VirtModeW = 1'b1;
    tick(); tick(); tick();
    expect_val("reset.hgeip", K_HGEIP, 0, 64'h0);
    expect_outs("reset", 0, 1'b0, 1'b0, 1'b0, 5'd0);
    drain();

    tick();
    reset = 1'b0; GEIRaw = '0; HVIP_REGW = '0; HGEIE_REGW = '0;
    HIDELEG_REGW = '0; HIE_REGW = '0; VirtModeW = 1'b0; PrivilegeModeW = 2'b11;
    repeat (LAT + 2) tick();

    // Capture latency and bit-0 hardwiring.
    tick(); GEIRaw = 7'b0000100;
    expect_val("cap.before", K_HGEIP, LAT - 1, 64'h0);
    expect_val("cap.after",  K_HGEIP, LAT,     64'h8);
    expect_val("cap.sgeip",  K_SGEIP, LAT + 1, 64'h0);
    drain();

    // SGEIP with hgeie; bit 0 of hgeie has no effect.
    tick(); HGEIE_REGW = 64'h8;
    expect_val("sgeip.en3", K_SGEIP, 1, 64'h1);
    drain();
    tick(); HGEIE_REGW = 64'h1;
    expect_val("sgeip.en0", K_SGEIP, 1, 64'h0);
    drain();
    tick(); HGEIE_REGW = 64'h9;
    expect_val("sgeip.en03", K_SGEIP, 1, 64'h1);
    drain();
    tick(); HGEIE_REGW = '0;

    // VGEIN selection, including out-of-range values and switch without glitch.
    tick(); HSTATUS_REGW = 64'd3 << 12;
    expect_val("vgein3.old", K_VSEIP, 0, 64'h0);
    expect_val("vgein3",     K_VSEIP, 1, 64'h1);
    drain();
    tick(); HSTATUS_REGW = '0;
    expect_val("vgein0.old", K_VSEIP, 0, 64'h1);
    expect_val("vgein0",     K_VSEIP, 1, 64'h0);
    drain();
    tick(); HSTATUS_REGW = 64'd9 << 12;
    expect_val("vgein9", K_VSEIP, 1, 64'h0);
    drain();
    tick(); HSTATUS_REGW = 64'd4 << 12;
    expect_val("vgein4", K_VSEIP, 1, 64'h0);
    drain();
    tick(); HSTATUS_REGW = '0;

    // Priority VSEI > VSSI > VSTI in VU mode.
    tick(); VirtModeW = 1'b1; PrivilegeModeW = PRIV_U; VSSIEW = 1'b0;
    HVIP_REGW = 12'h444; HIE_REGW = 64'h444; HIDELEG_REGW = 64'h444;
    expect_outs("prio.all", 1, 1'b0, 1'b1, 1'b1, 5'd9);
    drain();
    tick(); HVIP_REGW = 12'h044;
    expect_val("prio.hold", K_CAUSE, 0, 64'd9);
    expect_outs("prio.ssti", 1, 1'b0, 1'b0, 1'b1, 5'd1);
    drain();
    tick(); HVIP_REGW = 12'h040;
    expect_outs("prio.ti", 1, 1'b0, 1'b0, 1'b1, 5'd5);
    drain();
    tick(); HIDELEG_REGW = 64'h404;
    expect_outs("prio.nodeleg", 1, 1'b0, 1'b0, 1'b0, 5'd0);
    drain();
    tick(); HVIP_REGW = '0; HIDELEG_REGW = 64'h444; HSTATUS_REGW = 64'd3 << 12;
    expect_outs("prio.gei", 1, 1'b0, 1'b1, 1'b1, 5'd9);
    drain();
    tick(); HSTATUS_REGW = '0;

    // Mode gating.
    tick(); PrivilegeModeW = PRIV_S; VSSIEW = 1'b0; HVIP_REGW = 12'h004;
    expect_outs("gate.s_sie0", 1, 1'b0, 1'b0, 1'b0, 5'd0);
    drain();
    tick(); VSSIEW = 1'b1;
    expect_outs("gate.s_sie1", 1, 1'b0, 1'b0, 1'b1, 5'd1);
    drain();
    tick(); VirtModeW = 1'b0;
    expect_outs("gate.v0", 1, 1'b0, 1'b0, 1'b0, 5'd0);
    drain();
    tick(); VirtModeW = 1'b1; PrivilegeModeW = 2'b11;
    expect_outs("gate.m", 1, 1'b0, 1'b0, 1'b0, 5'd0);
    drain();
    tick(); PrivilegeModeW = PRIV_U; VSSIEW = 1'b0;
    expect_outs("gate.u", 1, 1'b0, 1'b0, 1'b1, 5'd1);
    drain();

    // Stall holds capture and outputs; release picks up the new level.
    tick(); StallW = 1'b1; GEIRaw = 7'b0000001; HVIP_REGW = '0;
    expect_val("stall.hgeip", K_HGEIP, LAT + 1, 64'h8);
    expect_val("stall.pend",  K_PEND,  LAT + 1, 64'h1);
    expect_val("stall.cause", K_CAUSE, LAT + 1, 64'd1);
    drain();
    tick(); StallW = 1'b0;
    expect_val("unstall.hgeip", K_HGEIP, 1, 64'h2);
    expect_val("unstall.pend",  K_PEND,  1, 64'h0);
    expect_val("unstall.cause", K_CAUSE, 1, 64'd0);
    drain();

    // Reset asserted while stalled clears everything.
    tick(); HVIP_REGW = 12'h004; HGEIE_REGW = 64'h2; HSTATUS_REGW = 64'd1 << 12;
    expect_outs("prestall", 1, 1'b1, 1'b1, 1'b1, 5'd9);
    drain();
    tick(); StallW = 1'b1; reset = 1'b1;
    expect_val("rststall.hgeip", K_HGEIP, 1, 64'h0);
    expect_outs("rststall", 1, 1'b0, 1'b0, 1'b0, 5'd0);
    drain();
    tick(); reset = 1'b0; StallW = 1'b0; HVIP_REGW = '0; HSTATUS_REGW = '0;
    expect_val("postrst.before", K_HGEIP, LAT - 1, 64'h0);
    expect_val("postrst.after",  K_HGEIP, LAT,     64'h2);
    drain();

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/hvirq.md
# hvirq

Hypervisor virtual-interrupt unit, directly upstream of the hypervisor CSR file. It synchronizes and registers the guest-external-interrupt lines into hgeip, and derives SGEIP and the effective VSEIP. It selects the highest-priority VS-level interrupt that may be taken in the current virtualization mode. Outputs feed the CSR file's MIP_REGW/HIP read path and the trap logic.

## Interface
- P, cvw_t, configuration struct; uses P.XLEN, P.S_MODE, P.U_MODE, P.M_MODE
- GEILEN, 7, number of guest external interrupt lines (1..P.XLEN-1); hgeip bit 0 is always 0

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- GEIRaw  in  GEILEN  guest external interrupt lines, level, bit i-1 = guest i; asynchronous when HVIRQ_SYNC_EN is defined
- StallW  in  1  hold all registered outputs
- HSTATUS_REGW  in  P.XLEN  hstatus; VGEIN = bits 17:12
- HIDELEG_REGW  in  P.XLEN  hideleg
- HIE_REGW  in  P.XLEN  hie (VSSIE 2, VSTIE 6, VSEIE 10)
- HVIP_REGW  in  12  hvip
- HGEIE_REGW  in  P.XLEN  hgeie
- VSSIEW  in  1  vsstatus.SIE
- PrivilegeModeW  in  2  current privilege
- VirtModeW  in  1  V bit
- HGEIP_REGW  out  P.XLEN  hgeip, read-only view
- SGEIPM  out  1  mip.SGEIP (bit 12)
- VSEIPM  out  1  effective hip.VSEIP
- VSIntPendingM  out  1  a VS interrupt is takeable now
- VSIntCauseM  out  5  guest-visible cause of the selected interrupt

## Operation
- Capture: hgeip[GEILEN:1] <= synchronized GEIRaw each cycle when ~StallW. hgeip[0] and hgeip[XLEN-1:GEILEN+1] are hard 0.
- SGEIP = |(hgeip & HGEIE_REGW), with bit 0 of hgeie ignored.
- VSEIP = HVIP_REGW[10] | hgeip[VGEIN]. The hgeip term is 0 when VGEIN==0 or VGEIN>GEILEN.
- VS pending vector: VSSIP = HVIP_REGW[2], VSTIP = HVIP_REGW[6], VSEIP as above. Each is ANDed with the matching HIE_REGW bit and the matching HIDELEG_REGW bit.
- Takeable gate (V=1 only):
  - PrivilegeModeW==U → enabled
  - PrivilegeModeW==S → enabled iff VSSIEW
  - V=0 or M mode → VSIntPendingM=0
- Priority: VSEI > VSSI > VSTI. Guest causes are 9, 1 and 5 respectively (the HS cause minus 1).
- When nothing is pending, VSIntCauseM=0.

## Timing
- Reset: hgeip=0, synchronizer flops=0, SGEIPM=0, VSEIPM=0, VSIntPendingM=0, VSIntCauseM=0.
- Latency, GEIRaw to HGEIP_REGW:
  - 3 cycles with HVIRQ_SYNC_EN (2 sync flops + capture)
  - 1 cycle without
- SGEIPM, VSEIPM, VSIntPendingM and VSIntCauseM are registered: one cycle after any CSR/mode input change, and one cycle after an hgeip change.
- StallW=1: capture flop and output flops hold. Synchronizer flops keep shifting, so no edge is lost.
- Simultaneous pending interrupts: only the highest priority is reported. A lower-priority one appears in the cycle after the higher one clears.
- An hstatus.VGEIN write changes the VSEIPM source in the next cycle, with no glitch from the old source.
- Reset mid-stall: reset wins and clears everything.

## Configuration
- HVIRQ_SYNC_EN defined:
  - each GEIRaw bit passes through a 2-flop synchronizer before capture
  - the synchronizers are reset to 0
- Undefined: GEIRaw is sampled directly by the capture flop and must be synchronous to clk.

## Structure
- Shared package cvw:
  - VS interrupt bit indices 2, 6, 10
  - guest cause constants 1, 5, 9
  - VGEIN field bounds 17:12
- One sub-module: hvirqsync, a parameterized-width 2-flop synchronizer with synchronous reset. It is instantiated only under HVIRQ_SYNC_EN.

## Test plan
- Sync/capture: with HVIRQ_SYNC_EN, pulse GEIRaw=7'b0000100 high at cycle 0 → HGEIP_REGW=0x8 at cycle 3; hgeip[0] stays 0.
- SGEIP: hgeip=0x8, HGEIE=0x8 → SGEIPM=1; HGEIE=0x9 with hgeip=0x1-only raw bit 0 never set → SGEIPM=0.
- VGEIN select: hgeip=0x8 with VGEIN=3 → VSEIPM=1; VGEIN=0 → VSEIPM=0; VGEIN=9 with GEILEN=7 → VSEIPM=0.
- Priority: V=1, VU mode, hvip=0x444, hie=0x444, hideleg=0x444 → VSIntPendingM=1, cause 9; clear hvip[10] → cause 1; then clear hvip[2] → cause 5.
- Gating: V=1, S mode, VSSIEW=0, VSSI delegated and enabled → VSIntPendingM=0. Set VSSIEW=1 → 1 next cycle. V=0 → 0.
- Stall/reset: StallW=1 while GEIRaw rises → HGEIP_REGW held, then updates after stall drops; assert reset mid-stall → all outputs 0 next cycle.
